// File: rtl/flag_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_status_unit
// Description : NZCV status register with in-flight flag-writer tracking,
//               stale-flag stall generation and same-cycle EXE bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_status_unit #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  input  logic             id_issue,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  logic [3:0]       exe_flags,
  input  logic             flush,
  output logic [3:0]       status,
  output logic [3:0]       status_fwd,
  output logic             flag_stall,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             cnt_err
);

  localparam logic [3:0]       c_cond_al = 4'b1110;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  logic [3:0]       r_status;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_wr;
  logic             w_cond;
  logic             w_stall;
  logic             w_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_set;

  assign w_wr   = exe_valid & exe_s;
  assign w_cond = (id_cond != c_cond_al);

  // A single pending writer finishing this cycle is covered by the bypass.
  assign w_stall = id_valid & w_cond & (r_cnt > (w_wr ? c_cnt_one : c_cnt_zero));
  assign w_inc   = id_issue & id_valid & id_s & ~w_stall & ~flush;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush) begin
      w_cnt_nxt = c_cnt_zero;
    end else if (w_inc && !w_wr) begin
      if (r_cnt != c_cnt_max) begin
        w_cnt_nxt = r_cnt + c_cnt_one;
      end
    end else if (w_wr && !w_inc) begin
      if (r_cnt != c_cnt_zero) begin
        w_cnt_nxt = r_cnt - c_cnt_one;
      end
    end
  end

  // Any completion with nothing tracked is an underflow, even alongside an issue.
  assign w_err_set = ~flush &
                     ((w_inc & ~w_wr & (r_cnt == c_cnt_max)) |
                      (w_wr & (r_cnt == c_cnt_zero)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
      r_cnt    <= c_cnt_zero;
      r_err    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_status <= exe_flags;
      end
      r_cnt <= w_cnt_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign status      = r_status;
  assign status_fwd  = w_wr ? exe_flags : r_status;
  assign flag_stall  = w_stall;
  assign pending_cnt = r_cnt;
  assign cnt_err     = r_err;

endmodule
`default_nettype wire
